// File: rtl/fifo_rdstream_if.sv
// fifo_rdstream_if: groups the upstream FIFO read port and the downstream
// valid/ready stream used by fifo_rdstream.
//   master : the fifo_rdstream block (drives read strobe and stream outputs)
//   slave  : the surrounding logic (upstream FIFO and downstream consumer)
interface fifo_rdstream_if #(
    parameter int DW = 16
);
    // Upstream sync FIFO read port (1-cycle read latency)
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;

    // Downstream stream
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo_rdstream.sv
// fifo_rdstream: turns a 1-cycle-latency sync FIFO read port into a
// first-word-fall-through valid/ready stream.
//
// A read accepted in cycle N returns data in cycle N+1; an in-flight flag
// remembers that and the word is captured at the end of cycle N+1 into a
// 2-entry ordered skid buffer. Reads are only issued when the word is sure
// to have a slot on arrival, so the buffer can never overflow.
//
// Optional feature: define FIFO_RDSTREAM_CNT_EN to add the beat_count output,
// a CW-bit wrapping count of completed stream transfers.
module fifo_rdstream #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    fifo_rdstream_if.master bus
`ifdef FIFO_RDSTREAM_CNT_EN
    ,
    output logic [CW-1:0]   beat_count
`endif
);

    if (DW < 1 || CW < 1) begin : g_bad_param
        $error("fifo_rdstream: DW and CW must be at least 1");
    end

    logic [1:0]    occ;       // buffered entries, 0..2
    logic          inflight;  // a read was accepted last cycle
    logic [DW-1:0] entry0;    // head (oldest)
    logic [DW-1:0] entry1;    // second oldest
    logic          transfer;  // stream handshake this cycle
    logic          rd_en;
    logic [2:0]    fill;      // occupancy once this cycle's events settle

    assign bus.out_valid  = (occ != 2'd0);
    assign bus.out_data   = entry0;
    assign bus.fifo_rd_en = rd_en;

    // Handshake and read-issue decision; out_ready feeds rd_en directly so a
    // draining consumer keeps the read pipe full without a bubble.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        transfer = 1'b0;
        fill     = 3'd0;
        rd_en    = 1'b0;

        transfer = bus.out_valid && bus.out_ready;
        // occ + inflight never exceeds 2 and transfer implies occ >= 1, so
        // this never wraps.
        fill     = {1'b0, occ} + {2'b00, inflight} - {2'b00, transfer};
        rd_en    = !rst && !bus.fifo_empty && (fill < 3'd2);
    end

    // Control state: occupancy and in-flight tracking, cleared on reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            unique case ({inflight, transfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;   // idle, or capture and drain together
            endcase
        end
    end

    // Data path: capture arriving words behind the oldest entry, shift on
    // transfer, and keep order when both happen in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: the entries hold data only; occ alone says which are valid,
        // so they are deliberately left out of reset.
        unique case ({inflight, transfer})
            2'b10: begin
                if (occ == 2'd0) begin
                    entry0 <= bus.fifo_rd_data;
                end else begin
                    entry1 <= bus.fifo_rd_data;
                end
            end
            2'b01: begin
                entry0 <= entry1;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    entry0 <= bus.fifo_rd_data;
                end else begin
                    entry0 <= entry1;
                    entry1 <= bus.fifo_rd_data;
                end
            end
            default: begin
                entry0 <= entry0;
                entry1 <= entry1;
            end
        endcase
    end

`ifdef FIFO_RDSTREAM_CNT_EN
    // Completed-transfer counter, wraps modulo 2^CW.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
        end else if (transfer) begin
            beat_count <= beat_count + CW'(1);
        end
    end
`endif

    // An arrival into a full buffer with nothing leaving must be impossible.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(inflight && (occ == 2'd2) && !transfer)
    );

    a_occ_range : assert property (
        @(posedge clk) disable iff (rst)
        occ != 2'd3
    );

endmodule

// File: tb/tb_fifo_rdstream.sv
// tb_fifo_rdstream: directed self-checking bench for fifo_rdstream.
// A behavioural sync FIFO (1-cycle read latency, writes visible after the
// next clock edge) feeds the DUT; stream beats are collected and compared
// against hand-computed expected sequences.
// Build with +define+FIFO_RDSTREAM_CNT_EN to also cover beat_count.
module tb_fifo_rdstream;

    localparam int DW = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_rdstream_if #(.DW(DW)) bus ();

`ifdef FIFO_RDSTREAM_CNT_EN
    logic [CW-1:0] beat_count;
`endif

    fifo_rdstream #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef FIFO_RDSTREAM_CNT_EN
        ,
        .beat_count (beat_count)
`endif
    );

    // ---------------- upstream FIFO model ----------------
    logic [DW-1:0] mem[$];
    logic [DW-1:0] pend[$];
    logic          fifo_empty_q = 1'b1;
    logic [DW-1:0] rd_q = '0;
    int            rd_cnt = 0;   // accepted reads since last reset
    int            xf_cnt = 0;   // stream transfers since last reset

    assign bus.fifo_empty   = fifo_empty_q;
    assign bus.fifo_rd_data = rd_q;

    always @(posedge clk) begin
        if (bus.fifo_rd_en && !fifo_empty_q && (mem.size() > 0)) begin
            rd_q <= mem.pop_front();
        end
        while (pend.size() > 0) mem.push_back(pend.pop_front());
        fifo_empty_q <= (mem.size() == 0);
        if (rst) begin
            rd_cnt <= 0;
            xf_cnt <= 0;
        end else begin
            if (bus.fifo_rd_en && !fifo_empty_q) rd_cnt <= rd_cnt + 1;
            if (bus.out_valid && bus.out_ready)  xf_cnt <= xf_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] got[$];

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Run ncyc cycles from a negedge. mode 0: ready low, 1: ready high,
    // 2: ready alternating starting high. Collects beats and checks that a
    // stalled beat is held and that reads never outrun buffer space.
    task automatic drain(input int ncyc, input int mode);
        logic          stall_prev = 1'b0;
        logic [DW-1:0] data_prev  = '0;
        for (int i = 0; i < ncyc; i++) begin
            bus.out_ready = (mode == 1) || ((mode == 2) && (i % 2 == 0));
            #1;
            if (stall_prev) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(data_prev));
            end
            check("outstanding_le2", 32'((rd_cnt - xf_cnt) <= 2), 32'd1);
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            stall_prev = bus.out_valid && !bus.out_ready;
            data_prev  = bus.out_data;
            @(negedge clk);
        end
    endtask

    task automatic check_got(input string tag, input logic [DW-1:0] base,
                             input int n);
        check({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < got.size() && i < n; i++) begin
            check({tag, "_data"}, 32'(got[i]), 32'(base + DW'(i)));
        end
    endtask

    int rd_base;

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
`ifdef FIFO_RDSTREAM_CNT_EN
        check("rst_beat_count", 32'(beat_count), 32'd0);
`endif
        rst = 1'b0;

        // Words 1..4, ready high: first beat two cycles after empty falls,
        // then one beat per cycle.
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) pend.push_back(DW'(i));
        @(negedge clk);
        check("t1_c0_empty", 32'(bus.fifo_empty), 32'd0);
        check("t1_c0_valid", 32'(bus.out_valid), 32'd0);
        check("t1_c0_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        @(negedge clk);
        check("t1_c1_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t1_valid", 32'(bus.out_valid), 32'd1);
            check("t1_data", 32'(bus.out_data), 32'(i));
        end
        @(negedge clk);
        check("t1_done_valid", 32'(bus.out_valid), 32'd0);

        // Three words against a stalled consumer: only two reads go out.
        got.delete();
        rd_base = rd_cnt;
        for (int i = 0; i < 3; i++) pend.push_back(16'h00A1 + DW'(i));
        drain(6, 0);
        check("t2_reads", 32'(rd_cnt - rd_base), 32'd2);
        check("t2_valid", 32'(bus.out_valid), 32'd1);
        check("t2_head", 32'(bus.out_data), 32'h00A1);
        drain(6, 1);
        check_got("t2_drain", 16'h00A1, 3);

        // Continuous data with ready toggling.
        got.delete();
        for (int i = 0; i < 8; i++) pend.push_back(16'h0B01 + DW'(i));
        drain(30, 2);
        check_got("t3_toggle", 16'h0B01, 8);

        // Reset with one word buffered and one in flight.
        got.delete();
        rd_base = rd_cnt;
        pend.push_back(16'h00C1);
        pend.push_back(16'h00C2);
        drain(3, 0);
        check("t4_pre_reads", 32'(rd_cnt - rd_base), 32'd2);
        check("t4_pre_outstanding", 32'(rd_cnt - xf_cnt), 32'd2);
        check("t4_pre_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t4_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        @(negedge clk);
        check("t4_after_valid", 32'(bus.out_valid), 32'd0);
        check("t4_after_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t4_idle_valid", 32'(bus.out_valid), 32'd0);
        check("t4_idle_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        pend.push_back(16'h00D1);
        drain(8, 1);
        check_got("t4_fresh", 16'h00D1, 1);

        // Single word: empty low for one cycle, one read, one beat.
        got.delete();
        rd_base = rd_cnt;
        pend.push_back(16'h0E01);
        drain(6, 1);
        check("t5_reads", 32'(rd_cnt - rd_base), 32'd1);
        check_got("t5_single", 16'h0E01, 1);
        check("t5_rd_en_low", 32'(bus.fifo_rd_en), 32'd0);
        check("t5_empty", 32'(bus.fifo_empty), 32'd1);

        // 17 transfers after a fresh reset (beat_count wraps at 16).
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        for (int i = 0; i < 17; i++) pend.push_back(16'h1000 + DW'(i));
        drain(25, 1);
        check_got("t6_burst", 16'h1000, 17);
`ifdef FIFO_RDSTREAM_CNT_EN
        check("t6_beat_count", 32'(beat_count), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
